pipe_stage_latch: RTL
=====================

Name: pipe_stage_latch

Overview:
- Parametrised successor to the fixed IR/PC/ALU/MDR/CW pipeline latches; one instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the global load_latch/stall wiring with a per-stage valid/ready handshake and a 2-entry skid buffer, so backpressure (e.g. a cache miss) stalls locally without combinational ready chains.
- Squash, flush and bubble (NOP) generation are built in.
- Squash has two selectable modes: convert the beat to a NOP, or drop it.

Parameters:
- WORD_W, 16, width of one datapath word.
- NUM_WORDS, 4, number of payload words; word 0 is always IR.
- CTRL_W, CONTROL_WIDTH, control-word width.
- NOP_CW, LC3B_NOP_CW, control word emitted for bubbles and squashed beats.
- SQUASH_DROP, 0, 0 = squashed beat becomes NOP and occupies a slot; 1 = squashed beat is discarded.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  latch can accept a beat; registered, depends on state only.
- in_words  in  NUM_WORDS*WORD_W  payload; word 0 (LSBs) is IR.
- in_cw  in  CTRL_W  control word.
- squash_in  in  1  qualifies the beat accepted this cycle as squashed.
- flush  in  1  synchronous clear of all held beats.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_words  out  NUM_WORDS*WORD_W  head payload; all zero when empty.
- out_cw  out  CTRL_W  head control word; NOP_CW when empty.
- occupancy  out  2  held beats, 0..2.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Upstream may not change in_words or in_cw while in_valid=1 and in_ready=0.
- Storage: main register (the head, drives the outputs) and skid register.
- States: EMPTY (occupancy 0), HALF (1), FULL (2).
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
- Transitions, evaluated in priority order:
  - flush=1: next state EMPTY; any in_fire that cycle is discarded; out_fire that cycle still completes.
  - EMPTY: in_fire -> HALF, main <= beat.
  - HALF:
    - in_fire & out_fire -> HALF, main <= beat.
    - in_fire only -> FULL, skid <= beat.
    - out_fire only -> EMPTY.
  - FULL:
    - out_fire -> HALF, main <= skid.
    - in_fire is impossible because in_ready=0.
- Squash, applied only on in_fire with squash_in=1:
  - SQUASH_DROP=0: stored beat has IR=0, cw=NOP_CW, and the other words passed through.
  - SQUASH_DROP=1: no write and no state change for the input side; the out side still transitions normally.
- Empty outputs: out_words=0 and out_cw=NOP_CW (combinational mux), so a downstream stage that ignores out_valid sees a NOP.
- Reset (async assert, sync release): state EMPTY, both entries cleared to words=0 and cw=NOP_CW. Outputs after reset: in_ready=1, out_valid=0, occupancy=0, out_words=0, out_cw=NOP_CW.
  - Reset mid-transfer discards all held beats; no partial state survives.
- Latency and throughput:
  - Beat accepted in cycle N is visible on out_* in cycle N+1 when the latch was EMPTY, or when it was HALF with out_fire.
  - Full throughput is 1 beat/cycle with out_ready held high.
  - With out_ready low, the latch absorbs 2 beats and then deasserts in_ready.
- Data ordering is strictly FIFO; no beat is duplicated or reordered.

Decomposition:
- lc3b_types package additions:
  - LC3B_NOP_CW constant (3'b1, zeros, alu_add, 2'b11 field layout), replacing the literal currently duplicated in the stage latches.
  - pipe_state_t enum {EMPTY, HALF, FULL}.
- Entries: reuse the existing generic register module, parametrised by width, for the main and skid entries.
- No new sub-module.

Test Plan:
- Reset, then drive in_valid=1 with IR=16'h1234, cw=C1 and out_ready=1 -> out_valid next cycle, out_words[15:0]=16'h1234, out_cw=C1, occupancy=1.
- Hold out_ready=0 while sending beats A, B, C -> A and B accepted; in_ready=0 from the cycle after B is accepted; C is held upstream; occupancy=2. Then raise out_ready -> outputs A, B, C on consecutive cycles.
- SQUASH_DROP=0, squash_in=1 on beat IR=16'hBEEF -> output IR=0, out_cw=NOP_CW, out_valid=1. Repeat with SQUASH_DROP=1 -> no output beat appears and occupancy stays unchanged.
- In FULL (A head, B skid), assert flush with out_ready=1 -> A completes that cycle; next cycle state EMPTY, out_cw=NOP_CW, out_words=0, in_ready=1.
- Assert rst_n=0 asynchronously mid-stream, between clock edges -> outputs immediately show out_valid=0, occupancy=0, out_cw=NOP_CW, without waiting for a clock edge.
- Random in_valid/out_ready, 10k cycles, scoreboard -> output sequence equals input sequence with squash rules applied, and no handshake-protocol violations.

Source files
------------

// File: rtl/pipe_stage_latch_pkg.sv
// Shared pipeline-latch types: the canonical NOP control word and the skid-buffer state encoding.
package pipe_stage_latch_pkg;

  localparam int CONTROL_WIDTH = 16;

  typedef enum logic [2:0] {
    alu_add  = 3'b000,
    alu_and  = 3'b001,
    alu_not  = 3'b010,
    alu_xor  = 3'b011,
    alu_sll  = 3'b100,
    alu_srl  = 3'b101,
    alu_sra  = 3'b110,
    alu_pass = 3'b111
  } alu_op_t;

  // Field layout: [15:13] opclass, [12:5] enables, [4:2] alu op, [1:0] writeback select.
  localparam logic [CONTROL_WIDTH-1:0] LC3B_NOP_CW = {3'b001, 8'h00, alu_add, 2'b11};

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  function automatic logic [1:0] pipe_occupancy(input pipe_state_t s);
    return logic'(s == FULL) ? 2'd2 : ((s == HALF) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/pipe_stage_latch_reg.sv
// Generic load-enabled register with async active-low reset to a parameterised value.
// Latency: 1 cycle from ld to q. No backpressure; loads whenever ld is high.
module pipe_stage_latch_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline stage latch: 2-entry skid buffer with squash, flush and NOP bubbles on empty.
// Latency: 1 cycle into an empty (or draining half-full) latch; 1 beat/cycle throughput.
// Backpressure: absorbs 2 beats with out_ready low; in_ready is decoded from state only.
module pipe_stage_latch
  import pipe_stage_latch_pkg::*;
#(
  parameter int                WORD_W      = 16,
  parameter int                NUM_WORDS   = 4,
  parameter int                CTRL_W      = CONTROL_WIDTH,
  parameter logic [CTRL_W-1:0] NOP_CW      = LC3B_NOP_CW,
  parameter bit                SQUASH_DROP = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WORDS*WORD_W-1:0] in_words,
  input  logic [CTRL_W-1:0]           in_cw,
  input  logic                        squash_in,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*WORD_W-1:0] out_words,
  output logic [CTRL_W-1:0]           out_cw,
  output logic [1:0]                  occupancy
);

  localparam int PW = NUM_WORDS * WORD_W;
  localparam int EW = PW + CTRL_W;
  localparam logic [PW-1:0] IR_MASK = PW'({WORD_W{1'b1}});
  localparam logic [EW-1:0] ENTRY_RST = {{PW{1'b0}}, NOP_CW};

  pipe_state_t state_q, state_d;

  logic          in_fire, out_fire, accept;
  logic          main_ld, skid_ld;
  logic [EW-1:0] beat, main_d, main_q, skid_q;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = pipe_occupancy(state_q);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A dropped squash or a flush means the input side sees no beat at all.
  assign accept = in_fire & ~flush & ~(squash_in & SQUASH_DROP);

  always_comb begin
    beat = {in_words, in_cw};
    if (squash_in && !SQUASH_DROP) begin
      beat = {in_words & ~IR_MASK, NOP_CW};
    end
  end

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = beat;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            main_ld = 1'b1;
          end
        end
        HALF: begin
          if (accept && out_fire) begin
            main_ld = 1'b1;
          end else if (accept) begin
            state_d = FULL;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = HALF;
            main_ld = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_stage_latch_reg #(
    .WIDTH   (EW),
    .RST_VAL (ENTRY_RST)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_stage_latch_reg #(
    .WIDTH   (EW),
    .RST_VAL (ENTRY_RST)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (skid_ld),
    .d     (beat),
    .q     (skid_q)
  );

  // Empty latch presents a bubble so consumers ignoring out_valid still see a NOP.
  assign out_words = (state_q == EMPTY) ? '0 : main_q[EW-1:CTRL_W];
  assign out_cw    = (state_q == EMPTY) ? NOP_CW : main_q[CTRL_W-1:0];

endmodule
